// File: rtl/control_unit.sv
// control_unit: microcoded T-state sequencer emitting one control word per clock.
// Fetch is T0-T1, execute is T2-T4 with per-opcode early termination; a halt
// latch freezes the sequencer until reset.
module control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] opcode,
    input  logic       flag_zero,
    input  logic       flag_carry,
    output logic       pc_oe,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       mar_load,
    output logic       ram_oe,
    output logic       ram_we,
    output logic       ir_load,
    output logic       ir_oe,
    output logic       a_load,
    output logic       a_oe,
    output logic       b_load,
    output logic       alu_oe,
    output logic       alu_sub,
    output logic       flags_load,
    output logic       out_load,
    output logic       halted,
    output logic [2:0] step
);

    localparam int unsigned STEP_W = 3;

    typedef enum logic [STEP_W-1:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } tstate_e;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_STA = 4'h4,
        OP_LDI = 4'h5,
        OP_JMP = 4'h6,
        OP_JC  = 4'h7,
        OP_JZ  = 4'h8,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;

    // One bit per datapath strobe; the whole word is zeroed in reset and halt.
    typedef struct packed {
        logic pc_oe;
        logic pc_inc;
        logic pc_load;
        logic mar_load;
        logic ram_oe;
        logic ram_we;
        logic ir_load;
        logic ir_oe;
        logic a_load;
        logic a_oe;
        logic b_load;
        logic alu_oe;
        logic alu_sub;
        logic flags_load;
        logic out_load;
    } ctl_t;

    tstate_e step_q;
    tstate_e step_d;
    logic    halted_q;
    logic    halt_set_c;
    logic    last_c;
    ctl_t    micro_c;
    ctl_t    ctl_c;

    // Microcode decode: control word and terminating-step flag for the current T-state.
    always_comb begin
        micro_c = '0;
        last_c  = 1'b1;
        unique case (step_q)
            T0: begin
                micro_c.pc_oe    = 1'b1;
                micro_c.mar_load = 1'b1;
                last_c           = 1'b0;
            end
            T1: begin
                micro_c.ram_oe  = 1'b1;
                micro_c.ir_load = 1'b1;
                micro_c.pc_inc  = 1'b1;
                last_c          = 1'b0;
            end
            T2: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        micro_c.ir_oe    = 1'b1;
                        micro_c.mar_load = 1'b1;
                        last_c           = 1'b0;
                    end
                    OP_LDI: begin
                        micro_c.ir_oe  = 1'b1;
                        micro_c.a_load = 1'b1;
                    end
                    OP_JMP: begin
                        micro_c.ir_oe   = 1'b1;
                        micro_c.pc_load = 1'b1;
                    end
                    OP_JC: begin
                        micro_c.ir_oe   = flag_carry;
                        micro_c.pc_load = flag_carry;
                    end
                    OP_JZ: begin
                        micro_c.ir_oe   = flag_zero;
                        micro_c.pc_load = flag_zero;
                    end
                    OP_OUT: begin
                        micro_c.a_oe     = 1'b1;
                        micro_c.out_load = 1'b1;
                    end
                    default: begin
                        // NOP, HLT and undefined opcodes idle here and end.
                        micro_c = '0;
                    end
                endcase
            end
            T3: begin
                case (opcode)
                    OP_LDA: begin
                        micro_c.ram_oe = 1'b1;
                        micro_c.a_load = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        micro_c.ram_oe = 1'b1;
                        micro_c.b_load = 1'b1;
                        last_c         = 1'b0;
                    end
                    OP_STA: begin
                        micro_c.a_oe   = 1'b1;
                        micro_c.ram_we = 1'b1;
                    end
                    default: begin
                        micro_c = '0;
                    end
                endcase
            end
            T4: begin
                case (opcode)
                    OP_ADD, OP_SUB: begin
                        micro_c.alu_oe     = 1'b1;
                        micro_c.a_load     = 1'b1;
                        micro_c.flags_load = 1'b1;
                        micro_c.alu_sub    = (opcode == OP_SUB);
                    end
                    default: begin
                        micro_c = '0;
                    end
                endcase
            end
            default: begin
                // Unreachable encodings terminate so the counter returns to T0.
                micro_c = '0;
                last_c  = 1'b1;
            end
        endcase
    end

    // Output gating and next-step selection.
    always_comb begin
        ctl_c      = micro_c;
        step_d     = T0;
        halt_set_c = 1'b0;
        if (!reset || halted_q) begin
            ctl_c = '0;
        end
        if (!last_c && (step_q != T4)) begin
            step_d = tstate_e'(STEP_W'(step_q) + STEP_W'(1));
        end
        if ((step_q == T2) && (opcode == OP_HLT)) begin
            halt_set_c = 1'b1;
        end
    end

    // T-state counter and halt latch; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            step_q   <= T0;
            halted_q <= 1'b0;
        end else if (!halted_q) begin
            step_q <= step_d;
            if (halt_set_c) begin
                halted_q <= 1'b1;
            end
        end
    end

    assign pc_oe      = ctl_c.pc_oe;
    assign pc_inc     = ctl_c.pc_inc;
    assign pc_load    = ctl_c.pc_load;
    assign mar_load   = ctl_c.mar_load;
    assign ram_oe     = ctl_c.ram_oe;
    assign ram_we     = ctl_c.ram_we;
    assign ir_load    = ctl_c.ir_load;
    assign ir_oe      = ctl_c.ir_oe;
    assign a_load     = ctl_c.a_load;
    assign a_oe       = ctl_c.a_oe;
    assign b_load     = ctl_c.b_load;
    assign alu_oe     = ctl_c.alu_oe;
    assign alu_sub    = ctl_c.alu_sub;
    assign flags_load = ctl_c.flags_load;
    assign out_load   = ctl_c.out_load;
    assign halted     = halted_q;
    assign step       = STEP_W'(step_q);

endmodule

// File: doc/control_unit.md
# control_unit

Microcoded sequencer that sits directly downstream of the instruction register: it consumes the latched `opcode`/`operand` split and emits one bus control word per clock. It steps a T-state counter through fetch (T0–T1) and execute (T2–T4). Execute ends early where the instruction allows, and a halt latch freezes the machine. All datapath loads, bus output enables, PC and RAM strobes, and flag updates in the CPU originate here.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low reset (asserted when 0).
- `opcode`  in  4  from instruction register; valid from T2 onward.
- `flag_zero`  in  1  latched Z flag from flags register.
- `flag_carry`  in  1  latched C flag from flags register.
- `pc_oe`, `pc_inc`, `pc_load`  out  1 each  program counter drive bus / increment / load from bus.
- `mar_load`  out  1  memory address register load.
- `ram_oe`, `ram_we`  out  1 each  RAM drive bus / write bus into RAM.
- `ir_load`, `ir_oe`  out  1 each  instruction register load / drive operand nibble on bus.
- `a_load`, `a_oe`, `b_load`  out  1 each  A register load / drive, B register load.
- `alu_oe`, `alu_sub`, `flags_load`  out  1 each  ALU result drive, subtract select, flags capture.
- `out_load`  out  1  output register load.
- `halted`  out  1  halt latch state.
- `step`  out  3  current T-state (0–4), for debug display.

## Operation
- State:
  - `step` is 3 bits and takes values 0–4 only.
  - `halted` is 1 bit.
- Control outputs are combinational from (`step`, `opcode`, flags, `halted`, `reset`).
- At most one `*_oe` is high in any cycle.
- Fetch:
  - T0: `pc_oe`, `mar_load`.
  - T1: `ram_oe`, `ir_load`, `pc_inc`.
- Execute, by opcode. Every step not listed for an opcode drives all controls low and is the terminating step.
  - 0x0 NOP: T2 idle, then end.
  - 0x1 LDA: T2 `ir_oe`,`mar_load`; T3 `ram_oe`,`a_load`, then end.
  - 0x2 ADD: T2 `ir_oe`,`mar_load`; T3 `ram_oe`,`b_load`; T4 `alu_oe`,`a_load`,`flags_load`, then end.
  - 0x3 SUB: same as ADD, with `alu_sub` high in T4 only.
  - 0x4 STA: T2 `ir_oe`,`mar_load`; T3 `a_oe`,`ram_we`, then end.
  - 0x5 LDI: T2 `ir_oe`,`a_load`, then end.
  - 0x6 JMP: T2 `ir_oe`,`pc_load`, then end.
  - 0x7 JC: T2 `ir_oe`,`pc_load` only if `flag_carry`=1; otherwise idle. Ends after T2 either way.
  - 0x8 JZ: T2 as JC, gated by `flag_zero`.
  - 0xE OUT: T2 `a_oe`,`out_load`, then end.
  - 0xF HLT: T2 all controls low; sets `halted` at the end of T2.
  - 0x9–0xD: treated as NOP.
- Step advance:
  - After the terminating step of an instruction, `step` goes to 0.
  - Otherwise `step` increments.
  - `step` never exceeds 4; from 4 it always goes to 0.
- Halt:
  - While `halted`=1, `step` holds and every control output is 0.
  - Only `reset` clears `halted`.
- Reset (`reset`=0 at an edge):
  - Sets `step`=0 and `halted`=0, mid-instruction or not.
  - While `reset`=0, all control outputs are forced to 0 combinationally.
  - `step` and `halted` read 0 after the first edge with `reset` low.

## Timing
- Reset values: `step`=0, `halted`=0, all control outputs 0 while `reset` is low.
- First cycle after release is T0 (`pc_oe`=`mar_load`=1).
- Instruction length in cycles, including fetch:
  - 3: NOP, LDI, JMP, JC, JZ, OUT, HLT, undefined opcodes.
  - 4: LDA, STA.
  - 5: ADD, SUB.
- `opcode` is sampled only in T2–T4. It reflects the byte loaded at the end of T1; changes during T0/T1 are ignored.
- Flags for JC/JZ are sampled combinationally in T2, so a flags update from a preceding ADD/SUB T4 is visible.
- `halted` rises on the edge closing HLT's T2. Controls are 0 from the next cycle onward, and `step` freezes at 0.

## Test plan
- Release `reset` with opcode=0x5 -> cycle 0: `pc_oe`,`mar_load`=1; cycle 1: `ram_oe`,`ir_load`,`pc_inc`=1; cycle 2: `ir_oe`,`a_load`=1; cycle 3: `step`=0 again.
- opcode=0x2 ADD -> `step` sequence 0,1,2,3,4,0. T4 shows `alu_oe`,`a_load`,`flags_load`=1 and `alu_sub`=0. Repeat with 0x3 -> identical except `alu_sub`=1 in T4.
- opcode=0x7 with `flag_carry`=0 -> T2 has no controls, next `step`=0. Repeat with `flag_carry`=1 -> T2 `ir_oe`,`pc_load`=1. Same pair of checks for 0x8 using `flag_zero`.
- opcode=0xF -> `halted`=1 after T2. Hold 10 cycles: `step`=0 and all controls 0 throughout. Pulse `reset`=0 for one edge -> `halted`=0, next cycle is T0.
- Assert `reset`=0 during T3 of LDA -> controls 0 in that same cycle, `step`=0 after the edge. Release -> fetch restarts at T0.
- Sweep opcodes 0x9–0xD -> each runs 3 cycles with T2 controls all 0. Across every opcode, assert no cycle has two `*_oe` signals high.
